// File: rtl/armedf_pkg.sv
// Shared constants and types for the sound CPU interface.
//   IPL_NONE / IPL_VBL      : 68000 interrupt priority encodings (active-low)
//   Z80_IRQ_PERIOD_DEFAULT  : default Z80 timer period in Z80 clock enables
//   latch_byte_t            : 68000 -> Z80 sound command byte
package armedf_pkg;
  localparam logic [2:0] IPL_NONE = 3'b111;
  localparam logic [2:0] IPL_VBL  = 3'b110;
  localparam int unsigned Z80_IRQ_PERIOD_DEFAULT = 512;
  typedef logic [7:0] latch_byte_t;
endpackage

// File: rtl/sound_irq_ctrl_edge_rise.sv
// edge_rise: registered rising-edge detector.
//   clk_sys : system clock
//   reset_n : asynchronous active-low reset, clears the history bit
//   d       : level input
//   rise    : high in the first cycle d is high (combinational from d)
// The history bit resets to 0, so a level already high when reset is
// released is reported as an edge on the first clock.
module edge_rise (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) d_q <= 1'b0;
    else          d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/sound_irq_ctrl.sv
// sound_irq_ctrl: 68000 -> Z80 sound latch, 68000 vblank IRQ (level 1) and
// Z80 periodic timer interrupt with acknowledge handling.
// Ports:
//   clk_sys, reset_n          : clock, asynchronous active-low reset
//   m68k_din/rw/lds_n         : 68000 bus (only din[7:0] used)
//   sound_latch_cs, irq_ack_cs: decoded 68000 selects
//   vbl                       : vertical blank level
//   m68k_ipl_n                : 68000 IPL, 3'b110 while vblank pending
//   z80_clk_en, IORQ_n, M1_n  : Z80 clock enable and bus control
//   z80_latch_r_cs/clr_cs     : decoded Z80 latch read / clear selects
//   latch_dout                : latch contents to the Z80 data mux
//   z80_int_n                 : Z80 INT, active-low
// Optional build macro SOUND_IRQ_DEBUG_EN adds saturating event counters
// dbg_latch_wr, dbg_latch_rd and dbg_z80_irq_lost.
// No valid/ready handshakes here: every select acts once per bus cycle on
// the rising edge of its qualifying condition.
module sound_irq_ctrl
  import armedf_pkg::*;
#(
  parameter int unsigned IRQ_PERIOD = Z80_IRQ_PERIOD_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [15:0] m68k_din,
  input  logic        m68k_rw,
  input  logic        m68k_lds_n,
  input  logic        sound_latch_cs,
  input  logic        irq_ack_cs,
  input  logic        vbl,
  output logic [2:0]  m68k_ipl_n,
  input  logic        z80_clk_en,
  input  logic        IORQ_n,
  input  logic        M1_n,
  input  logic        z80_latch_r_cs,
  input  logic        z80_latch_clr_cs,
  output logic [7:0]  latch_dout,
`ifdef SOUND_IRQ_DEBUG_EN
  output logic [15:0] dbg_latch_wr,
  output logic [15:0] dbg_latch_rd,
  output logic [15:0] dbg_z80_irq_lost,
`endif
  output logic        z80_int_n
);
  localparam logic [15:0] CNT_MAX = 16'(IRQ_PERIOD - 1);

  logic wr_rise, clr_rise, rd_rise, ack_rise, vbl_rise, inta_rise;
  latch_byte_t latch_q;
  logic        m68k_pend, z80_pend;
  logic [15:0] cnt_q;
  logic        wrap;

  edge_rise u_wr   (.clk_sys, .reset_n, .d(sound_latch_cs & ~m68k_rw & ~m68k_lds_n), .rise(wr_rise));
  edge_rise u_clr  (.clk_sys, .reset_n, .d(z80_latch_clr_cs), .rise(clr_rise));
  edge_rise u_rd   (.clk_sys, .reset_n, .d(z80_latch_r_cs),   .rise(rd_rise));
  edge_rise u_ack  (.clk_sys, .reset_n, .d(irq_ack_cs & ~m68k_rw), .rise(ack_rise));
  edge_rise u_vbl  (.clk_sys, .reset_n, .d(vbl),              .rise(vbl_rise));
  edge_rise u_inta (.clk_sys, .reset_n, .d(~IORQ_n & ~M1_n),  .rise(inta_rise));

  // Latch: a 68000 write takes priority over a coincident Z80 clear.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)      latch_q <= '0;
    else if (wr_rise)  latch_q <= m68k_din[7:0];
    else if (clr_rise) latch_q <= '0;
  end

  // 68000 vblank pending: set wins over acknowledge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)       m68k_pend <= 1'b0;
    else if (vbl_rise)  m68k_pend <= 1'b1;
    else if (ack_rise)  m68k_pend <= 1'b0;
  end

  assign wrap = z80_clk_en && (cnt_q == CNT_MAX);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)        cnt_q <= '0;
    else if (wrap)       cnt_q <= '0;
    else if (z80_clk_en) cnt_q <= cnt_q + 16'd1;
  end

  // Z80 pending: set wins over INT-ack; a wrap while pending is dropped.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)       z80_pend <= 1'b0;
    else if (wrap)      z80_pend <= 1'b1;
    else if (inta_rise) z80_pend <= 1'b0;
  end

  assign latch_dout = latch_q;
  assign m68k_ipl_n = m68k_pend ? IPL_VBL : IPL_NONE;
  assign z80_int_n  = ~z80_pend;

`ifdef SOUND_IRQ_DEBUG_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dbg_latch_wr     <= '0;
      dbg_latch_rd     <= '0;
      dbg_z80_irq_lost <= '0;
    end else begin
      if (wr_rise && dbg_latch_wr != 16'hFFFF) dbg_latch_wr <= dbg_latch_wr + 16'd1;
      if (rd_rise && dbg_latch_rd != 16'hFFFF) dbg_latch_rd <= dbg_latch_rd + 16'd1;
      if (wrap && z80_pend && dbg_z80_irq_lost != 16'hFFFF)
        dbg_z80_irq_lost <= dbg_z80_irq_lost + 16'd1;
    end
  end
  logic unused_dbg;
  assign unused_dbg = &{1'b0, m68k_din[15:8]};
`else
  logic unused_dbg;
  assign unused_dbg = &{1'b0, m68k_din[15:8], rd_rise};
`endif
endmodule

// File: tb/tb_sound_irq_ctrl.sv
// Directed testbench for sound_irq_ctrl with IRQ_PERIOD = 4.
// Inputs change on the falling edge; outputs are sampled on the next
// falling edge, i.e. half a cycle after the active rising edge.
module tb_sound_irq_ctrl;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [15:0] m68k_din;
  logic        m68k_rw, m68k_lds_n, sound_latch_cs, irq_ack_cs, vbl;
  logic [2:0]  m68k_ipl_n;
  logic        z80_clk_en, IORQ_n, M1_n, z80_latch_r_cs, z80_latch_clr_cs;
  logic [7:0]  latch_dout;
  logic        z80_int_n;
`ifdef SOUND_IRQ_DEBUG_EN
  logic [15:0] dbg_latch_wr, dbg_latch_rd, dbg_z80_irq_lost;
`endif

  int checks = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk_sys = ~clk_sys;

  sound_irq_ctrl #(.IRQ_PERIOD(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .m68k_din(m68k_din), .m68k_rw(m68k_rw), .m68k_lds_n(m68k_lds_n),
    .sound_latch_cs(sound_latch_cs), .irq_ack_cs(irq_ack_cs), .vbl(vbl),
    .m68k_ipl_n(m68k_ipl_n), .z80_clk_en(z80_clk_en),
    .IORQ_n(IORQ_n), .M1_n(M1_n),
    .z80_latch_r_cs(z80_latch_r_cs), .z80_latch_clr_cs(z80_latch_clr_cs),
    .latch_dout(latch_dout),
`ifdef SOUND_IRQ_DEBUG_EN
    .dbg_latch_wr(dbg_latch_wr), .dbg_latch_rd(dbg_latch_rd),
    .dbg_z80_irq_lost(dbg_z80_irq_lost),
`endif
    .z80_int_n(z80_int_n)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic idle_bus();
    m68k_din = 16'h0000; m68k_rw = 1'b1; m68k_lds_n = 1'b1;
    sound_latch_cs = 1'b0; irq_ack_cs = 1'b0;
    z80_latch_r_cs = 1'b0; z80_latch_clr_cs = 1'b0;
    IORQ_n = 1'b1; M1_n = 1'b1;
  endtask

  task automatic m68k_write(input logic [15:0] d, input logic lds_n);
    m68k_din = d; m68k_rw = 1'b0; m68k_lds_n = lds_n; sound_latch_cs = 1'b1;
  endtask

  // One Z80 enable followed by two idle cycles; then check INT.
  task automatic z80_enable(input string tag, input logic exp_int_n);
    z80_clk_en = 1'b1; tick();
    z80_clk_en = 1'b0;
    check(tag, {15'd0, z80_int_n}, {15'd0, exp_int_n});
    tick(); tick();
  endtask

  task automatic z80_int_ack();
    IORQ_n = 1'b0; M1_n = 1'b0; tick();
    check("z80_inta", {15'd0, z80_int_n}, 16'd1);
    IORQ_n = 1'b1; M1_n = 1'b1; tick();
  endtask

  initial begin
    idle_bus(); vbl = 1'b0; z80_clk_en = 1'b0; reset_n = 1'b0;
    @(negedge clk_sys); @(negedge clk_sys);
    check("rst_latch", {8'd0, latch_dout}, 16'h0000);
    check("rst_ipl", {13'd0, m68k_ipl_n}, 16'h0007);
    check("rst_int", {15'd0, z80_int_n}, 16'h0001);
    reset_n = 1'b1; tick();

    // latch write held for 4 cycles; data change mid-hold must not re-latch
    m68k_write(16'h12A5, 1'b0); tick();
    check("wr_first", {8'd0, latch_dout}, 16'h00A5);
    m68k_din = 16'h12FF; tick(); tick(); tick();
    check("wr_held", {8'd0, latch_dout}, 16'h00A5);
    idle_bus(); tick();
    m68k_write(16'h0011, 1'b1); tick(); tick();
    check("wr_udsonly", {8'd0, latch_dout}, 16'h00A5);
    idle_bus(); tick();
    m68k_din = 16'h0022; m68k_lds_n = 1'b0; sound_latch_cs = 1'b1; tick();
    check("rd_ignored", {8'd0, latch_dout}, 16'h00A5);
    idle_bus(); tick();

    // Z80 clear, then clear coincident with a write
    z80_latch_clr_cs = 1'b1; tick();
    check("clr", {8'd0, latch_dout}, 16'h0000);
    idle_bus(); tick();
    z80_latch_clr_cs = 1'b1; m68k_write(16'h003C, 1'b0); tick();
    check("clr_wr_collide", {8'd0, latch_dout}, 16'h003C);
    idle_bus(); tick();
    z80_latch_r_cs = 1'b1; tick(); tick();
    check("z80_read", {8'd0, latch_dout}, 16'h003C);
    idle_bus(); tick();

    // 68000 vblank IRQ
    vbl = 1'b1; tick();
    check("vbl_set", {13'd0, m68k_ipl_n}, 16'h0006);
    irq_ack_cs = 1'b1; m68k_rw = 1'b0; tick();
    check("vbl_ack", {13'd0, m68k_ipl_n}, 16'h0007);
    idle_bus(); vbl = 1'b0; tick();
    vbl = 1'b1; irq_ack_cs = 1'b1; m68k_rw = 1'b0; tick();
    check("vbl_ack_collide", {13'd0, m68k_ipl_n}, 16'h0006);
    idle_bus(); tick();
    irq_ack_cs = 1'b1; m68k_rw = 1'b0; tick();
    check("vbl_ack2", {13'd0, m68k_ipl_n}, 16'h0007);
    idle_bus(); vbl = 1'b0; tick();

    // Z80 timer, period 4
    z80_enable("tmr_e1", 1'b1); z80_enable("tmr_e2", 1'b1);
    z80_enable("tmr_e3", 1'b1); z80_enable("tmr_e4", 1'b0);
    z80_int_ack();
    z80_enable("tmr_e5", 1'b1); z80_enable("tmr_e6", 1'b1);
    z80_enable("tmr_e7", 1'b1); z80_enable("tmr_e8", 1'b0);
    // lost IRQ: wrap at e12 while still pending
    z80_enable("lost_e9", 1'b0); z80_enable("lost_e10", 1'b0);
    z80_enable("lost_e11", 1'b0); z80_enable("lost_e12", 1'b0);
    z80_int_ack();
    z80_enable("lost_e13", 1'b1); z80_enable("lost_e14", 1'b1);
    z80_enable("lost_e15", 1'b1); z80_enable("lost_e16", 1'b0);
`ifdef SOUND_IRQ_DEBUG_EN
    check("dbg_lost", dbg_z80_irq_lost, 16'd1);
    check("dbg_wr", dbg_latch_wr, 16'd2);
    check("dbg_rd", dbg_latch_rd, 16'd1);
`endif
    z80_int_ack();

    // reset mid-operation: latch 55, both IRQs pending, counter 3
    m68k_write(16'h0055, 1'b0); tick();
    idle_bus(); vbl = 1'b1; tick(); vbl = 1'b0;
    z80_enable("pre_e1", 1'b1); z80_enable("pre_e2", 1'b1);
    z80_enable("pre_e3", 1'b1);
    check("pre_latch", {8'd0, latch_dout}, 16'h0055);
    check("pre_ipl", {13'd0, m68k_ipl_n}, 16'h0006);
    z80_enable("pre_e4", 1'b0);
    z80_enable("pre_e5", 1'b0); z80_enable("pre_e6", 1'b0);
    z80_enable("pre_e7", 1'b0);
    reset_n = 1'b0; #1;
    check("mid_rst_latch", {8'd0, latch_dout}, 16'h0000);
    check("mid_rst_ipl", {13'd0, m68k_ipl_n}, 16'h0007);
    check("mid_rst_int", {15'd0, z80_int_n}, 16'h0001);
`ifdef SOUND_IRQ_DEBUG_EN
    check("mid_rst_dbg", dbg_z80_irq_lost, 16'd0);
`endif
    @(negedge clk_sys); reset_n = 1'b1; tick();
    z80_enable("post_e1", 1'b1); z80_enable("post_e2", 1'b1);
    z80_enable("post_e3", 1'b1); z80_enable("post_e4", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
